// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter: buffers incoming words and
// launches them one at a time, following the transmitter's busy handshake.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS     = 8,
  parameter int DEPTH_LOG2       = 4,
  parameter int BUSY_WAIT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  output logic                    in_ready,
  input  logic                    tx_busy,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam int WaitW = (BUSY_WAIT_CYCLES > 1) ? $clog2(BUSY_WAIT_CYCLES) : 1;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [WaitW-1:0]    WaitLast  = WaitW'(BUSY_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e                  state_q;
  logic [PAYLOAD_BITS-1:0] mem_q [Depth];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    tx_en_q;
  logic [PAYLOAD_BITS-1:0] tx_data_q;
  logic [WaitW-1:0]        wait_cnt_q;

  logic full, empty, push, pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  // A pop sees only the registered count, so a same-cycle push never falls through.
  assign pop   = (state_q == IDLE) && !empty && !tx_busy;

  assign in_ready = !full;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Setting has priority so an overflow in the clearing cycle is not lost.
    if (in_valid && full) overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_en_q <= 1'b0;
          if (pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_en_q   <= 1'b1;
            state_q   <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en_q    <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= WAIT_BUSY;
        end
        // A transmitter that never acknowledges must not stall the queue forever.
        WAIT_BUSY: begin
          tx_en_q <= 1'b0;
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (wait_cnt_q == WaitLast) begin
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          tx_en_q <= 1'b0;
          if (!tx_busy) state_q <= IDLE;
        end
        default: begin
          tx_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected launches, a
// monitor pops and compares them on every tx_en strobe.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       tx_busy = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         launch_times[$];
  int         launches = 0;
  int         cyc = 0;
  logic [7:0] last_data = 8'h00;

  bit         force_busy = 1'b0;
  bit         never_busy = 1'b0;
  int         busy_len = 20;
  int         busy_left = 0;
  bit         pend = 1'b0;

  uart_tx_fifo #(
    .PAYLOAD_BITS(8),
    .DEPTH_LOG2(4),
    .BUSY_WAIT_CYCLES(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .tx_busy(tx_busy),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .count(count),
    .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit accept, input bit clr);
    in_valid     = 1'b1;
    in_data      = d;
    clr_overflow = clr;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    in_valid     = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && !(exp_q.size() == 0 && count == 5'd0); i++) @(negedge clk);
    tick(12);
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  // Transmitter model: busy rises the cycle after a strobe and lasts busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        busy_left = busy_len;
        pend      = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (tx_en && resetn && !never_busy) pend = 1'b1;
      tx_busy = force_busy || (busy_left > 0);
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        last_data = 8'h00;
      end else if (tx_en) begin
        launches++;
        launch_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_tx_en", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_data_order", {24'h0, tx_data}, {24'h0, e});
        end
        last_data = tx_data;
      end else begin
        checkOutput("tx_data_hold", {24'h0, tx_data}, {24'h0, last_data});
      end
    end
  end

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int l0;
    int t0;

    #3;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_tx_en", tx_en, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    // Single word: strobe two cycles after the push, held afterwards.
    l0 = launches;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("single_count", count, 1);
    tick(1);
    checkOutput("single_tx_en", tx_en, 1);
    checkOutput("single_tx_data", tx_data, 8'hA5);
    tick(1);
    checkOutput("single_pulse_width", tx_en, 0);
    checkOutput("single_hold", tx_data, 8'hA5);
    tick(30);
    checkOutput("single_launches", launches - l0, 1);

    // Burst into a blocked transmitter, then overflow handling.
    force_busy = 1'b1;
    tick(2);
    l0 = launches;
    for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 1'b1, 1'b0);
    checkOutput("burst_count", count, 16);
    checkOutput("burst_in_ready", in_ready, 0);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_count", count, 16);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    checkOutput("ovf_set_wins", overflow, 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);
    checkOutput("ovf_count_kept", count, 16);
    busy_len   = 3;
    force_busy = 1'b0;
    drain();
    checkOutput("burst_launches", launches - l0, 16);

    // Asynchronous reset with words pending.
    force_busy = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) applyStimulus(8'h30 + 8'(i), 1'b1, 1'b0);
    checkOutput("mid_count", count, 5);
    #2 resetn = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("arst_count", count, 0);
    checkOutput("arst_tx_en", tx_en, 0);
    checkOutput("arst_in_ready", in_ready, 1);
    checkOutput("arst_tx_data", tx_data, 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    force_busy = 1'b0;
    l0 = launches;
    @(negedge clk);
    tick(10);
    checkOutput("arst_no_launch", launches - l0, 0);
    checkOutput("arst_count_after", count, 0);

    // Move pointers to wr=15/rd=12, then push during an IDLE pop.
    force_busy = 1'b1;
    tick(2);
    for (int i = 0; i < 12; i++) applyStimulus(8'h40 + 8'(i), 1'b1, 1'b0);
    force_busy = 1'b0;
    drain();
    force_busy = 1'b1;
    tick(2);
    applyStimulus(8'h50, 1'b1, 1'b0);
    applyStimulus(8'h51, 1'b1, 1'b0);
    applyStimulus(8'h52, 1'b1, 1'b0);
    checkOutput("wrap_count_pre", count, 3);
    force_busy = 1'b0;
    tick(1);
    l0 = launches;
    applyStimulus(8'hC0, 1'b1, 1'b0);
    checkOutput("wrap_count_hold", count, 3);
    checkOutput("wrap_tx_en", tx_en, 1);
    checkOutput("wrap_tx_data", tx_data, 8'h50);
    applyStimulus(8'hC1, 1'b1, 1'b0);
    applyStimulus(8'hC2, 1'b1, 1'b0);
    drain();
    checkOutput("wrap_launches", launches - l0, 6);

    // Silent transmitter: each launch times out after four WAIT_BUSY cycles.
    never_busy = 1'b1;
    tick(2);
    launch_times.delete();
    l0 = launches;
    t0 = cyc;
    applyStimulus(8'h61, 1'b1, 1'b0);
    applyStimulus(8'h62, 1'b1, 1'b0);
    applyStimulus(8'h63, 1'b1, 1'b0);
    tick(25);
    checkOutput("timeout_launches", launches - l0, 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("timeout_launch%0d_cycle", k),
                  (k < launch_times.size()) ? launch_times[k] - t0 : -1, 2 + 6 * k);
    end
    checkOutput("timeout_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and transmit sequencer that sits directly upstream of the UART transmitter (`uart_tool_tx`). It accepts payload words from any producer, such as the RX valid/data pair in the loopback top, and stores them in a circular FIFO. It then launches them one at a time into the transmitter, honouring the transmitter's `uart_tx_busy` handshake. Back-to-back received bytes are therefore not lost while the transmitter is still shifting out the previous byte.

## Interface
- `PAYLOAD_BITS`, 8, width of one data word.
- `DEPTH_LOG2`, 4, FIFO depth is 2^DEPTH_LOG2 entries (16).
- `BUSY_WAIT_CYCLES`, 4, maximum cycles to wait for `tx_busy` to rise after a launch before giving up; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  producer presents `in_data` this cycle.
- `in_data`  in  PAYLOAD_BITS  word to enqueue.
- `in_ready`  out  1  FIFO not full; combinational from the registered count.
- `tx_busy`  in  1  transmitter busy, connected to `uart_tx_busy`.
- `tx_en`  out  1  one-cycle launch strobe, connected to `uart_tx_en`.
- `tx_data`  out  PAYLOAD_BITS  word being launched, connected to `uart_tx_data`.
- `count`  out  DEPTH_LOG2+1  current number of stored words (0 … 2^DEPTH_LOG2).
- `overflow`  out  1  sticky: a word was offered while the FIFO was full.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- **Storage:** 2^DEPTH_LOG2 × PAYLOAD_BITS array.
  - Write and read pointers are DEPTH_LOG2 bits wide and wrap naturally modulo depth.
  - `count` is a separate register; full = (`count` == 2^DEPTH_LOG2), empty = (`count` == 0).
- **Push:** `in_valid && !full` at the edge writes `in_data` at the write pointer and increments the write pointer.
  - `in_valid && full` drops the word. `overflow` is set and the pointers and `count` do not change.
  - Full is judged on the pre-edge `count`. A push while full is dropped even if a pop occurs in the same cycle.
- **Pop:** performed by the drain FSM only. It copies `mem[rd_ptr]` into the `tx_data` register and increments the read pointer.
- **Count update:** push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- **Overflow flag:** if `clr_overflow` and a new overflow occur in the same cycle, set wins and `overflow` stays 1.
- **Drain FSM states:**
  - IDLE: if `count` != 0 and `!tx_busy`, pop and go to LAUNCH; otherwise stay.
  - LAUNCH: `tx_en` = 1 for exactly this cycle; clear the wait counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - If `tx_busy`, go to WAIT_DONE.
    - Else increment the wait counter. When the counter reaches BUSY_WAIT_CYCLES−1, go to IDLE; the word is treated as sent and is not re-queued.
  - WAIT_DONE: when `!tx_busy`, go to IDLE.
- **`tx_data` stability:** `tx_data` changes only on a pop. It is held stable from LAUNCH until the next pop.
- **`tx_en`:** never asserted outside LAUNCH, so at most one strobe per popped word.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - Pointers = 0, `count` = 0, `tx_en` = 0, `tx_data` = 0, `overflow` = 0.
  - Hence `in_ready` = 1.
  - Memory contents are not reset.
- **Reset mid-operation:** asserting `resetn` = 0 asynchronously discards all stored words and any in-flight launch state. Outputs take their reset values immediately, with no clock edge required.
- **Latency:** with the FIFO empty, FSM in IDLE and `tx_busy` = 0, `in_valid` in cycle N gives:
  - `count` = 1 in cycle N+1;
  - pop at the end of N+1;
  - `tx_en` = 1 in cycle N+2, with `tx_data` valid that same cycle.
- **Issue spacing:** minimum spacing between consecutive `tx_en` strobes is 4 cycles (LAUNCH, WAIT_BUSY, WAIT_DONE, IDLE). The real spacing is dominated by the transmitter frame time.
- **`tx_busy` sampling:** `tx_busy` high while in IDLE blocks launches. Words accumulate in the FIFO until `tx_busy` falls.
- **Simultaneous events:** a push into an empty FIFO in the same cycle the FSM is in IDLE is not visible to the FSM until the next cycle. There is no fall-through path.

## Test plan
- **Reset:** drive `resetn` = 0 mid-stream with `count` = 5 → `count` = 0, `tx_en` = 0, `in_ready` = 1 immediately. No further `tx_en` until a new push.
- **Single word:** push 0xA5 at cycle N with a transmitter model that raises `tx_busy` 1 cycle after `tx_en` for 20 cycles → `tx_en` pulses for exactly 1 cycle at N+2, with `tx_data` = 0xA5 held until the next pop.
- **Burst ordering:** push 0x01…0x10 back-to-back (16 words) with the transmitter busy → `count` reaches 16 and `in_ready` = 0. Output order is then 0x01…0x10, with exactly 16 `tx_en` pulses.
- **Overflow:** with the FIFO full, push 0xFF, then the same push together with `clr_overflow` → 0xFF never transmitted and `overflow` = 1 (set wins). A later `clr_overflow` alone → `overflow` = 0.
- **Simultaneous push/pop at wrap:** with the write pointer at 15 and `count` = 3, push in the same cycle as an IDLE pop → `count` stays 3 and the write pointer wraps to 0. Data order is preserved across the wrap.
- **Busy timeout:** a transmitter model that never raises `tx_busy` → the FSM returns to IDLE after BUSY_WAIT_CYCLES (4) WAIT_BUSY cycles and launches the next word. Each word is strobed exactly once.
